// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, arbiter state encoding and the writeback request
// record used by wb_arbiter and wb_holdbuf.
package wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

  // One writeback request: valid flag, destination register, write data.
  // The register field is called rd because "reg" is a reserved word.
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  localparam wb_req_t WB_REQ_NONE = '{valid: 1'b0, rd: '0, data: '0};

  // A request only turns into a regfile write when it targets a nonzero register.
  function automatic logic is_write(input wb_req_t req);
    return req.valid && (req.rd != {REG_W{1'b0}});
  endfunction

  // Saturating increment for the 4-bit starvation counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : (value + 4'd1);
  endfunction

endpackage

// File: rtl/wb_holdbuf.sv
// wb_holdbuf: single-entry holding buffer for a multdiv result that lost
// arbitration to the main pipeline. Load has priority over clear.
module wb_holdbuf
  import wb_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              load,
  input  logic              clear,
  input  wb_req_t           in_req,
  output logic              buf_valid,
  output logic [REG_W-1:0]  buf_reg,
  output logic [DATA_W-1:0] buf_data
);

  wb_req_t entry_r;

  // Capture a losing multdiv result, or drop the entry once it is consumed.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      entry_r <= WB_REQ_NONE;
    end else if (load) begin
      entry_r <= in_req;
    end else if (clear) begin
      entry_r <= WB_REQ_NONE;
    end else begin
      entry_r <= entry_r;
    end
  end

  assign buf_valid = entry_r.valid;
  assign buf_reg   = entry_r.rd;
  assign buf_data  = entry_r.data;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates the single regfile write port between the main
// pipeline writeback and the multdiv unit. A multdiv result that collides
// with a pipeline write is parked in wb_holdbuf and written on the next free
// cycle; if the pipeline keeps writing for STARVE_LIMIT cycles, the pipeline
// is stalled for one cycle so the parked result can drain.
// Optional feature: define WB_BYPASS_EN to add two combinational bypass
// read ports that forward the in-flight regfile write.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              pipe_valid,
  input  logic [REG_W-1:0]  pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              ctrl_writeEn,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              stall_pipe
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_W-1:0]  byp_readRegA,
  input  logic [REG_W-1:0]  byp_readRegB,
  output logic              byp_hitA,
  output logic              byp_hitB,
  output logic [DATA_W-1:0] byp_dataA,
  output logic [DATA_W-1:0] byp_dataB
`endif
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  wb_state_e         state_r;
  wb_state_e         state_next_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_next_s;
  logic [3:0]        cnt_inc_s;

  wb_req_t           pipe_req_s;
  wb_req_t           md_req_s;
  wb_req_t           buf_req_s;
  wb_req_t           grant_s;
  logic              pipe_wr_s;
  logic              md_wr_s;

  logic              buf_load_s;
  logic              buf_clear_s;
  logic              buf_valid_s;
  logic [REG_W-1:0]  buf_reg_s;
  logic [DATA_W-1:0] buf_data_s;

  logic              stall_s;
  logic              md_ready_s;

  logic              wr_en_r;
  logic [REG_W-1:0]  wr_reg_r;
  logic [DATA_W-1:0] wr_data_r;

  wb_holdbuf u_holdbuf (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .load       (buf_load_s),
    .clear      (buf_clear_s),
    .in_req     (md_req_s),
    .buf_valid  (buf_valid_s),
    .buf_reg    (buf_reg_s),
    .buf_data   (buf_data_s)
  );

  // Pack the three request sources into uniform records.
  always_comb begin
    pipe_req_s = '{valid: pipe_valid,  rd: pipe_reg,  data: pipe_data};
    md_req_s   = '{valid: 1'b1,        rd: md_reg,    data: md_data};
    buf_req_s  = '{valid: buf_valid_s, rd: buf_reg_s, data: buf_data_s};
    pipe_wr_s  = is_write(pipe_req_s);
    md_wr_s    = md_valid && (md_reg != {REG_W{1'b0}});
    cnt_inc_s  = sat_inc4(cnt_r);
  end

  // Arbitration FSM: next state, counter, buffer control and write grant.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    grant_s      = WB_REQ_NONE;
    buf_load_s   = 1'b0;
    buf_clear_s  = 1'b0;
    stall_s      = 1'b0;
    md_ready_s   = 1'b0;
    if (ctrl_reset) begin
      // Register reset takes care of state; keep handshakes quiet meanwhile.
      state_next_s = IDLE;
      cnt_next_s   = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          md_ready_s = 1'b1;
          cnt_next_s = 4'd0;
          if (pipe_wr_s) begin
            grant_s = pipe_req_s;
            // A same-register md result is already stale: the pipe wins.
            if (md_wr_s && (md_reg != pipe_reg)) begin
              buf_load_s   = 1'b1;
              cnt_next_s   = 4'd1;
              state_next_s = (LIMIT_C <= 4'd1) ? FORCE : HOLD;
            end else begin
              state_next_s = IDLE;
            end
          end else if (md_wr_s) begin
            grant_s      = md_req_s;
            state_next_s = IDLE;
          end else begin
            state_next_s = IDLE;
          end
        end
        HOLD: begin
          if (pipe_wr_s) begin
            grant_s = pipe_req_s;
            if (buf_valid_s && (pipe_reg == buf_reg_s)) begin
              // Write-after-write: the newer pipe value supersedes the buffer.
              buf_clear_s  = 1'b1;
              cnt_next_s   = 4'd0;
              state_next_s = IDLE;
            end else begin
              cnt_next_s   = cnt_inc_s;
              state_next_s = (cnt_inc_s >= LIMIT_C) ? FORCE : HOLD;
            end
          end else begin
            grant_s      = buf_req_s;
            buf_clear_s  = 1'b1;
            cnt_next_s   = 4'd0;
            state_next_s = IDLE;
          end
        end
        FORCE: begin
          // Pipeline holds its request this cycle; the buffer drains.
          stall_s      = 1'b1;
          grant_s      = buf_req_s;
          buf_clear_s  = 1'b1;
          cnt_next_s   = 4'd0;
          state_next_s = IDLE;
        end
        default: begin
          buf_clear_s  = 1'b1;
          cnt_next_s   = 4'd0;
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Registered regfile write port: one-cycle pulse per granted request.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_en_r   <= 1'b0;
      wr_reg_r  <= {REG_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
    end else begin
      wr_en_r   <= grant_s.valid;
      wr_reg_r  <= grant_s.rd;
      wr_data_r <= grant_s.data;
    end
  end

  assign ctrl_writeEn  = wr_en_r;
  assign ctrl_writeReg = wr_reg_r;
  assign data_writeReg = wr_data_r;
  assign stall_pipe    = stall_s;
  assign md_ready      = md_ready_s;

`ifdef WB_BYPASS_EN
  // Forward the write currently on the regfile port to matching readers.
  always_comb begin
    byp_hitA  = 1'b0;
    byp_dataA = {DATA_W{1'b0}};
    byp_hitB  = 1'b0;
    byp_dataB = {DATA_W{1'b0}};
    if (wr_en_r && (byp_readRegA != {REG_W{1'b0}}) && (byp_readRegA == wr_reg_r)) begin
      byp_hitA  = 1'b1;
      byp_dataA = wr_data_r;
    end else begin
      byp_hitA  = 1'b0;
      byp_dataA = {DATA_W{1'b0}};
    end
    if (wr_en_r && (byp_readRegB != {REG_W{1'b0}}) && (byp_readRegB == wr_reg_r)) begin
      byp_hitB  = 1'b1;
      byp_dataB = wr_data_r;
    end else begin
      byp_hitB  = 1'b0;
      byp_dataB = {DATA_W{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter. Directed scenarios plus
// a randomized run checked against a pending-result reference model.
module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_reg = 5'd0;
  logic [31:0] pipe_data = 32'd0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_reg = 5'd0;
  logic [31:0] md_data = 32'd0;
  logic        md_ready;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall_pipe;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_readRegA = 5'd0;
  logic [4:0]  byp_readRegB = 5'd0;
  logic        byp_hitA;
  logic        byp_hitB;
  logic [31:0] byp_dataA;
  logic [31:0] byp_dataB;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: at most one parked multdiv result and how many
  // pipe-write cycles it has waited so far.
  bit          m_pend = 1'b0;
  logic [4:0]  m_reg = 5'd0;
  logic [31:0] m_data = 32'd0;
  int          m_waits = 0;

  bit          exp_stall, exp_ready, exp_en, exp_rst;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  logic        obs_stall, obs_ready, obs_en;
  logic [4:0]  obs_reg;
  logic [31:0] obs_data;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .pipe_valid    (pipe_valid),
    .pipe_reg      (pipe_reg),
    .pipe_data     (pipe_data),
    .md_valid      (md_valid),
    .md_reg        (md_reg),
    .md_data       (md_data),
    .md_ready      (md_ready),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg),
    .stall_pipe    (stall_pipe)
`ifdef WB_BYPASS_EN
    ,
    .byp_readRegA  (byp_readRegA),
    .byp_readRegB  (byp_readRegB),
    .byp_hitA      (byp_hitA),
    .byp_hitB      (byp_hitB),
    .byp_dataA     (byp_dataA),
    .byp_dataB     (byp_dataB)
`endif
  );

  always #5 clock = ~clock;

  // Apply one cycle of inputs, sample combinational outputs mid-cycle,
  // advance the model, then sample the registered write port after the edge.
  task automatic run_cycle(input bit rst, input bit pv, input logic [4:0] pr,
                           input logic [31:0] pd, input bit mv,
                           input logic [4:0] mr, input logic [31:0] mdd);
    ctrl_reset = rst; pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
    md_valid = mv; md_reg = mr; md_data = mdd;
    #1;
    obs_stall = stall_pipe;
    obs_ready = md_ready;
    exp_en = 1'b0; exp_reg = 5'd0; exp_data = 32'd0; exp_rst = rst;
    exp_stall = !rst && m_pend && (m_waits >= LIMIT);
    exp_ready = !rst && !m_pend;
    if (rst) begin
      m_pend = 1'b0; m_waits = 0;
    end else if (exp_stall) begin
      exp_en = 1'b1; exp_reg = m_reg; exp_data = m_data;
      m_pend = 1'b0; m_waits = 0;
    end else if (pv && pr != 5'd0) begin
      exp_en = 1'b1; exp_reg = pr; exp_data = pd;
      if (m_pend && pr == m_reg) begin
        m_pend = 1'b0; m_waits = 0;
      end else if (m_pend) begin
        m_waits = (m_waits >= 15) ? 15 : m_waits + 1;
      end else if (mv && mr != 5'd0 && mr != pr) begin
        m_pend = 1'b1; m_reg = mr; m_data = mdd; m_waits = 1;
      end
    end else if (m_pend) begin
      exp_en = 1'b1; exp_reg = m_reg; exp_data = m_data;
      m_pend = 1'b0; m_waits = 0;
    end else if (mv && mr != 5'd0) begin
      exp_en = 1'b1; exp_reg = mr; exp_data = mdd;
    end
    @(posedge clock);
    #1;
    obs_en = ctrl_writeEn; obs_reg = ctrl_writeReg; obs_data = data_writeReg;
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    run_cycle(1'b1, 1'b1, 5'd3, 32'hDEAD, 1'b1, 5'd4, 32'hBEEF);
    run_cycle(1'b1, 1'b1, 5'd5, 32'h1111, 1'b1, 5'd6, 32'h2222);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_md_ready: got %0b want 0", obs_ready); end
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", obs_stall); end
    checks++; if ({obs_en, obs_reg, obs_data} !== 38'd0) begin errors++; $display("FAIL reset_outputs: got en=%0b reg=%0d data=%h want all zero", obs_en, obs_reg, obs_data); end
    idle_cycle();
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL reset_idle_en: got %0b want 0", obs_en); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", obs_ready); end
  endtask

  task automatic test_pipe_only();
    run_cycle(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    checks++; if ({obs_en, obs_reg, obs_data} !== {1'b1, 5'd5, 32'h1234}) begin errors++; $display("FAIL pipe_only_write: got en=%0b reg=%0d data=%h want en=1 reg=5 data=00001234", obs_en, obs_reg, obs_data); end
    idle_cycle();
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL pipe_only_pulse: got en=%0b want 0", obs_en); end
  endtask

  task automatic test_collision();
    run_cycle(1'b0, 1'b1, 5'd3, 32'd7, 1'b1, 5'd9, 32'hFFFFFFD6);
    checks++; if ({obs_en, obs_reg, obs_data} !== {1'b1, 5'd3, 32'd7}) begin errors++; $display("FAIL collision_pipe: got en=%0b reg=%0d data=%h want r3=7", obs_en, obs_reg, obs_data); end
    idle_cycle();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL collision_ready_hold: got %0b want 0", obs_ready); end
    checks++; if ({obs_en, obs_reg, obs_data} !== {1'b1, 5'd9, 32'hFFFFFFD6}) begin errors++; $display("FAIL collision_md: got en=%0b reg=%0d data=%h want r9=ffffffd6", obs_en, obs_reg, obs_data); end
    idle_cycle();
    checks++; if (obs_ready !== 1'b1 || obs_en !== 1'b0) begin errors++; $display("FAIL collision_after: got ready=%0b en=%0b want ready=1 en=0", obs_ready, obs_en); end
  endtask

  task automatic test_starve();
    run_cycle(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    checks++; if (obs_reg !== 5'd1 || obs_en !== 1'b1) begin errors++; $display("FAIL starve_first: got en=%0b reg=%0d want r1", obs_en, obs_reg); end
    for (int k = 2; k <= 4; k++) begin
      run_cycle(1'b0, 1'b1, 5'(k), 32'(k), 1'b0, 5'd0, 32'd0);
      checks++; if (obs_stall !== 1'b0 || obs_ready !== 1'b0 || obs_reg !== 5'(k)) begin errors++; $display("FAIL starve_hold_%0d: got stall=%0b ready=%0b reg=%0d want 0 0 %0d", k, obs_stall, obs_ready, obs_reg, k); end
    end
    run_cycle(1'b0, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %0b want 1", obs_stall); end
    checks++; if ({obs_en, obs_reg, obs_data} !== {1'b1, 5'd9, 32'h99}) begin errors++; $display("FAIL starve_drain: got en=%0b reg=%0d data=%h want r9=99", obs_en, obs_reg, obs_data); end
    run_cycle(1'b0, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_stall !== 1'b0 || obs_ready !== 1'b1 || obs_reg !== 5'd5) begin errors++; $display("FAIL starve_resume: got stall=%0b ready=%0b reg=%0d want 0 1 5", obs_stall, obs_ready, obs_reg); end
  endtask

  task automatic test_waw();
    run_cycle(1'b0, 1'b1, 5'd2, 32'h1, 1'b1, 5'd9, 32'h77);
    run_cycle(1'b0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
    checks++; if ({obs_en, obs_reg, obs_data} !== {1'b1, 5'd9, 32'h55}) begin errors++; $display("FAIL waw_pipe: got en=%0b reg=%0d data=%h want r9=55", obs_en, obs_reg, obs_data); end
    idle_cycle();
    checks++; if (obs_en !== 1'b0 || obs_ready !== 1'b1) begin errors++; $display("FAIL waw_no_md: got en=%0b ready=%0b want en=0 ready=1", obs_en, obs_ready); end
    run_cycle(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'hAA);
    checks++; if ({obs_en, obs_reg, obs_data} !== {1'b1, 5'd6, 32'h66}) begin errors++; $display("FAIL same_reg_pipe: got en=%0b reg=%0d data=%h want r6=66", obs_en, obs_reg, obs_data); end
    idle_cycle();
    checks++; if (obs_en !== 1'b0 || obs_ready !== 1'b1) begin errors++; $display("FAIL same_reg_drop: got en=%0b ready=%0b want en=0 ready=1", obs_en, obs_ready); end
  endtask

  task automatic test_zero_reg();
    run_cycle(1'b0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'h1);
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL zero_reg_write: got en=%0b want 0", obs_en); end
    idle_cycle();
    checks++; if (obs_ready !== 1'b1 || obs_en !== 1'b0) begin errors++; $display("FAIL zero_reg_ready: got ready=%0b en=%0b want 1 0", obs_ready, obs_en); end
  endtask

  task automatic test_reset_in_hold();
    run_cycle(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hA0);
    run_cycle(1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    checks++; if (obs_ready !== 1'b0 || obs_stall !== 1'b0) begin errors++; $display("FAIL hold_reset_comb: got ready=%0b stall=%0b want 0 0", obs_ready, obs_stall); end
    checks++; if ({obs_en, obs_reg, obs_data} !== 38'd0) begin errors++; $display("FAIL hold_reset_out: got en=%0b reg=%0d data=%h want zero", obs_en, obs_reg, obs_data); end
    for (int k = 0; k < 2; k++) begin
      idle_cycle();
      checks++; if (obs_en !== 1'b0 || obs_ready !== 1'b1) begin errors++; $display("FAIL hold_reset_lost_%0d: got en=%0b ready=%0b want 0 1", k, obs_en, obs_ready); end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    run_cycle(1'b0, 1'b1, 5'd7, 32'hABCD, 1'b0, 5'd0, 32'd0);
    byp_readRegA = 5'd7; byp_readRegB = 5'd0;
    #1;
    checks++; if (byp_hitA !== 1'b1 || byp_dataA !== 32'hABCD) begin errors++; $display("FAIL bypass_a: got hit=%0b data=%h want 1 0000abcd", byp_hitA, byp_dataA); end
    checks++; if (byp_hitB !== 1'b0 || byp_dataB !== 32'd0) begin errors++; $display("FAIL bypass_b: got hit=%0b data=%h want 0 0", byp_hitB, byp_dataB); end
    byp_readRegA = 5'd3; byp_readRegB = 5'd7;
    #1;
    checks++; if (byp_hitA !== 1'b0 || byp_hitB !== 1'b1 || byp_dataB !== 32'hABCD) begin errors++; $display("FAIL bypass_swap: got hitA=%0b hitB=%0b dataB=%h want 0 1 0000abcd", byp_hitA, byp_hitB, byp_dataB); end
    idle_cycle();
    checks++; if (byp_hitB !== 1'b0 || byp_dataB !== 32'd0) begin errors++; $display("FAIL bypass_idle: got hit=%0b data=%h want 0 0", byp_hitB, byp_dataB); end
    byp_readRegA = 5'd0; byp_readRegB = 5'd0;
  endtask
`endif

  task automatic test_random();
    bit          rst, pv, mv;
    logic [4:0]  pr, mr;
    logic [31:0] pd, mdd;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      pv  = ($urandom_range(0, 9) < 8);
      mv  = ($urandom_range(0, 1) == 1);
      pr  = 5'($urandom_range(0, 7));
      mr  = 5'($urandom_range(0, 7));
      pd  = $urandom;
      mdd = $urandom;
      run_cycle(rst, pv, pr, pd, mv, mr, mdd);
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rand_stall[%0d]: got %0b want %0b", i, obs_stall, exp_stall); end
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %0b want %0b", i, obs_ready, exp_ready); end
      checks++; if (obs_en !== exp_en) begin errors++; $display("FAIL rand_en[%0d]: got %0b want %0b", i, obs_en, exp_en); end
      if (exp_en || exp_rst) begin
        checks++; if (obs_reg !== exp_reg || obs_data !== exp_data) begin errors++; $display("FAIL rand_write[%0d]: got reg=%0d data=%h want reg=%0d data=%h", i, obs_reg, obs_data, exp_reg, exp_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_collision();
    test_starve();
    test_waw();
    test_zero_reg();
    test_reset_in_hold();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive pipe-write cycles a buffered multdiv result may wait before stall is forced (legal 1..15).
REQ-002 SHALL have port clock  in  1  rising-edge clock for all state.
REQ-003 SHALL have port ctrl_reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports pipe_valid  in  1 / pipe_reg  in  5 / pipe_data  in  32  main-pipeline writeback request.
REQ-005 SHALL have ports md_valid  in  1 / md_reg  in  5 / md_data  in  32  multdiv result offer; md_ready  out  1  accept.
REQ-006 SHALL have ports ctrl_writeEn  out  1 / ctrl_writeReg  out  5 / data_writeReg  out  32  registered regfile write port.
REQ-007 SHALL have port stall_pipe  out  1  combinational request for the pipeline to hold its writeback this cycle.

Function
REQ-008 "Pipe write" SHALL mean pipe_valid=1 and pipe_reg!=0; pipe_valid with pipe_reg=0 SHALL be dropped silently.
REQ-009 MD accept SHALL occur when md_valid=1 and md_ready=1 at a rising edge; md_reg=0 accepts SHALL be consumed with no write.
REQ-010 Regfile write outputs SHALL be registered: a granted request appears on ctrl_writeEn/Reg/data exactly 1 cycle later for exactly 1 cycle; ctrl_writeEn=0 otherwise.
REQ-011 SHALL implement states IDLE, HOLD, FORCE; md_ready=1 only in IDLE.
REQ-012 IDLE: md accept without pipe write -> md granted, stay IDLE; md accept with pipe write -> pipe granted, md buffered, counter=1, go HOLD; pipe write alone -> pipe granted.
REQ-013 HOLD: no pipe write -> buffer granted, go IDLE; pipe write -> pipe granted, counter+1; counter reaching STARVE_LIMIT -> go FORCE.
REQ-014 FORCE: stall_pipe=1, pipe request ignored (pipeline holds it), buffer granted, go IDLE; stall_pipe=0 in all other states.
REQ-015 WAW: if a granted pipe write targets the buffered md_reg, buffer SHALL be discarded, go IDLE, no later md write.
REQ-016 Same-cycle pipe write and md accept to equal nonzero register SHALL grant pipe only and discard md.
REQ-017 Counter SHALL be 4 bits, saturating, cleared on entering IDLE.

Reset
REQ-018 ctrl_reset=1 at an edge SHALL set state IDLE, counter 0, buffer invalid, ctrl_writeEn=0, ctrl_writeReg=0, data_writeReg=0; stall_pipe=0 and md_ready=0 while ctrl_reset=1.
REQ-019 A buffered result present at reset SHALL be lost; md/pipe inputs during reset SHALL be ignored.

Configuration
REQ-020 Macro WB_BYPASS_EN SHALL, when defined, add ports byp_readRegA/B  in  5 and byp_hitA/B  out  1, byp_dataA/B  out  32.
REQ-021 With WB_BYPASS_EN: byp_hitX=1 and byp_dataX=data_writeReg when ctrl_writeEn=1 and ctrl_writeReg==byp_readRegX!=0, else hit=0, data=0; combinational.
REQ-022 Without WB_BYPASS_EN: those ports and logic SHALL not exist; all other behaviour identical.

Structure
REQ-023 Shared package wb_pkg SHALL hold state enum (IDLE/HOLD/FORCE), REG_W=5, DATA_W=32, and the wb request struct {valid, reg, data}.
REQ-024 One sub-module wb_holdbuf (single-entry buffer: load, clear, valid, reg, data) SHALL be used; arbitration FSM stays in wb_arbiter.

Verification
REQ-025 Pipe write r5=0x1234 alone -> next cycle ctrl_writeEn=1, ctrl_writeReg=5, data_writeReg=0x1234; following cycle ctrl_writeEn=0.
REQ-026 Pipe r3=7 with md r9=-42 same cycle -> cycle+1 writes r3=7, md_ready=0, cycle+2 writes r9=0xFFFFFFD6, md_ready=1.
REQ-027 Buffered md r9 with pipe writes r1..r4 back-to-back (STARVE_LIMIT=4) -> stall_pipe=1 in 5th cycle, r9 written next cycle, then IDLE.
REQ-028 Buffered md r9 then pipe write r9=0x55 -> only r9=0x55 written; no md write follows.
REQ-029 Pipe r0=0xFF and md r0=1 -> no write, md_ready stays 1; ctrl_reset while HOLD -> all outputs 0, buffered result never written.
REQ-030 WB_BYPASS_EN: write r7=0xABCD with byp_readRegA=7, byp_readRegB=0 -> byp_hitA=1, byp_dataA=0xABCD, byp_hitB=0.
